demux_1_to_n: RTL and testbench
===============================

Name: demux_1_to_n

Overview:
- Parameterized 1-to-N demultiplexer: routes one data bit to one of N outputs chosen by a binary select; all other outputs are 0.
- Primary output `out` is purely combinational.
- A registered copy, `out_q`, and a select-range error flag are provided for pipelined consumers in the datapath.

Parameters:
- N, default 8, number of outputs; legal range N >= 2, need not be a power of two.
- SEL_W (localparam), $clog2(N), select width; not overridable.

Ports:
- clk  input  1  system clock; used only by the registered outputs.
- rst  input  1  reset; asynchronous, active-high.
- data_in  input  1  data bit to route.
- sel  input  SEL_W  binary index of the target output.
- out  output  N  combinational demux result.
- sel_err  output  1  combinational; 1 when sel >= N.
- out_q  output  N  `out` registered on rising clk.
- sel_err_q  output  1  `sel_err` registered on rising clk.

Behaviour:
- Combinational path, zero latency:
  - out[i] = data_in when sel == i, else 0, for i in 0..N-1.
  - Any change on data_in or sel updates out with no clock.
- data_in = 0 → out = all zeros regardless of sel.
- Exactly one bit of out may be 1 at any time: the bit at index sel, and only when data_in = 1.
- sel >= N (possible only when N is not a power of two):
  - out = all zeros, sel_err = 1, regardless of data_in.
- sel or data_in containing X/Z: out behaviour is unspecified. Sim-only; no requirement.
- Registered path:
  - On rising clk with rst = 0: out_q <= out and sel_err_q <= sel_err.
  - One-cycle latency relative to the combinational outputs.
- Reset:
  - rst = 1 asynchronously forces out_q = 0 and sel_err_q = 0 immediately, without waiting for clk.
  - Registered outputs are held at 0 while rst is high.
  - The first update after rst deasserts happens on the next rising clk.
  - rst does not affect out or sel_err; the combinational path stays live during reset.
- Reset asserted mid-operation: registered outputs clear immediately; the combinational outputs keep tracking inputs.
- No state other than the out_q and sel_err_q registers; no handshake.
- Synthesizable; no latches.

Test Plan (N=8 unless noted):
- Select sweep, combinational: data_in=1, sel=0,1,2,7, each held 10 time units → out = 8'b00000001, 8'b00000010, 8'b00000100, 8'b10000000; sel_err=0.
- Zero data: data_in=0, sel=0 → out = 8'b00000000. Then sel=5 → out = 8'b00000000.
- Exhaustive one-hot check: data_in=1, all sel 0..7 → $countones(out)==1 and out[sel]==1.
- Registered path:
  - Release rst, then apply data_in=1, sel=3 before a rising clk → out_q = 8'b00001000 after that edge.
  - Change sel to 6 mid-cycle → out updates immediately; out_q stays 8'b00001000 until the next edge.
- Asynchronous reset: with out_q nonzero, assert rst between clock edges → out_q = 0 and sel_err_q = 0 immediately; out still equals the combinational value.
- Non-power-of-two, N=5 (SEL_W=3):
  - sel=4, data_in=1 → out = 5'b10000, sel_err=0.
  - sel=6 → out = 5'b00000, sel_err=1; after the next clk edge, sel_err_q=1.

Source files
------------

// File: rtl/demux_1_to_n.sv
// 1-to-N demultiplexer: combinational one-hot routing of data_in to out[sel],
// plus a registered copy of the result and of the select-range error flag.
module demux_1_to_n #(
  parameter int N = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data_in,
  input  logic [$clog2(N)-1:0]       sel,
  output logic [N-1:0]               out,
  output logic                       sel_err,
  output logic [N-1:0]               out_q,
  output logic                       sel_err_q
);

  localparam int SEL_W = $clog2(N);

  // One extra bit so N itself is representable when N is a power of two.
  localparam logic [SEL_W:0] N_EXT = N[SEL_W:0];

  logic [N-1:0] out_d;
  logic         sel_err_d;
  logic [N-1:0] out_reg_q;
  logic         sel_err_reg_q;

  always_comb begin
    sel_err_d = ({1'b0, sel} >= N_EXT);
    out_d     = '0;
    for (int i = 0; i < N; i++) begin
      out_d[i] = data_in && !sel_err_d && (sel == i[SEL_W-1:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg_q     <= '0;
      sel_err_reg_q <= 1'b0;
    end else begin
      out_reg_q     <= out_d;
      sel_err_reg_q <= sel_err_d;
    end
  end

  assign out       = out_d;
  assign sel_err   = sel_err_d;
  assign out_q     = out_reg_q;
  assign sel_err_q = sel_err_reg_q;

endmodule

// File: tb/tb_demux_1_to_n.sv
// Directed bench for demux_1_to_n: an N=8 instance and a non-power-of-two N=5 instance.
module tb_demux_1_to_n;

  logic       clk;
  logic       rst;
  logic       data8;
  logic [2:0] sel8;
  logic [7:0] out8;
  logic       err8;
  logic [7:0] out8_q;
  logic       err8_q;
  logic       data5;
  logic [2:0] sel5;
  logic [4:0] out5;
  logic       err5;
  logic [4:0] out5_q;
  logic       err5_q;

  int checks = 0;
  int errors = 0;

  demux_1_to_n #(.N(8)) u_dut8 (
    .clk(clk), .rst(rst), .data_in(data8), .sel(sel8),
    .out(out8), .sel_err(err8), .out_q(out8_q), .sel_err_q(err8_q)
  );

  demux_1_to_n #(.N(5)) u_dut5 (
    .clk(clk), .rst(rst), .data_in(data5), .sel(sel5),
    .out(out5), .sel_err(err5), .out_q(out5_q), .sel_err_q(err5_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_v;
    rst   = 1'b1;
    data8 = 1'b0;
    sel8  = 3'd0;
    data5 = 1'b0;
    sel5  = 3'd0;
    #2;
    chk("reset_out_q", out8_q, 8'h00);
    chk("reset_sel_err_q", {7'd0, err8_q}, 8'h00);

    // Combinational sweep while still in reset: comb path must be live.
    data8 = 1'b1;
    sel8 = 3'd0; #10; chk("sweep_sel0", out8, 8'b00000001);
    sel8 = 3'd1; #10; chk("sweep_sel1", out8, 8'b00000010);
    sel8 = 3'd2; #10; chk("sweep_sel2", out8, 8'b00000100);
    sel8 = 3'd7; #10; chk("sweep_sel7", out8, 8'b10000000);
    chk("sweep_sel_err", {7'd0, err8}, 8'h00);
    chk("sweep_out_q_in_reset", out8_q, 8'h00);

    data8 = 1'b0; sel8 = 3'd0; #1; chk("zero_data_sel0", out8, 8'h00);
    sel8 = 3'd5; #1; chk("zero_data_sel5", out8, 8'h00);

    data8 = 1'b1;
    for (int s = 0; s < 8; s++) begin
      sel8 = s[2:0];
      #1;
      chk("onehot_count", 8'($countones(out8)), 8'd1);
      exp_v = 8'd1 << s;
      chk("onehot_pos", out8, exp_v);
    end

    // Registered path: release reset away from a clock edge.
    @(negedge clk);
    rst   = 1'b0;
    data8 = 1'b1;
    sel8  = 3'd3;
    #1;
    chk("out_q_before_edge", out8_q, 8'h00);
    @(posedge clk); #1;
    chk("out_q_after_edge", out8_q, 8'b00001000);
    sel8 = 3'd6; #1;
    chk("comb_mid_cycle", out8, 8'b01000000);
    chk("out_q_hold_mid_cycle", out8_q, 8'b00001000);
    @(posedge clk); #1;
    chk("out_q_next_edge", out8_q, 8'b01000000);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1; #1;
    chk("async_rst_out_q", out8_q, 8'h00);
    chk("async_rst_sel_err_q", {7'd0, err8_q}, 8'h00);
    chk("async_rst_comb_live", out8, 8'b01000000);
    @(posedge clk); #1;
    chk("rst_held_out_q", out8_q, 8'h00);

    // Non-power-of-two instance.
    @(negedge clk);
    rst   = 1'b0;
    data5 = 1'b1;
    sel5  = 3'd4; #1;
    chk("n5_sel4_out", {3'd0, out5}, 8'b00010000);
    chk("n5_sel4_err", {7'd0, err5}, 8'h00);
    @(posedge clk); #1;
    chk("n5_sel4_out_q", {3'd0, out5_q}, 8'b00010000);
    sel5 = 3'd6; #1;
    chk("n5_sel6_out", {3'd0, out5}, 8'h00);
    chk("n5_sel6_err", {7'd0, err5}, 8'h01);
    chk("n5_err_q_before_edge", {7'd0, err5_q}, 8'h00);
    @(posedge clk); #1;
    chk("n5_sel6_err_q", {7'd0, err5_q}, 8'h01);
    chk("n5_sel6_out_q", {3'd0, out5_q}, 8'h00);
    data5 = 1'b0; sel5 = 3'd5; #1;
    chk("n5_sel5_err_data0", {7'd0, err5}, 8'h01);
    sel5 = 3'd2; #1;
    chk("n5_sel2_data0", {3'd0, out5}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
